demux_vc: RTL and testbench

Virtual-channel demultiplexer: receives the single merged 6-bit word stream produced by the VC mux and splits it back into VC0 and VC1 streams on the receive side of the link. Routing is decided by the VC class bit carried in each word. Each VC output has a 2-entry holding buffer so downstream FIFOs can apply backpressure without losing words. `ready_in` is registered.

---
 rtl/demux_vc_pkg.sv | 18 +
 rtl/demux_vc_if.sv | 26 ++
 rtl/demux_vc_skid_buffer.sv | 53 +++++
 rtl/demux_vc.sv | 87 ++++++++
 tb/tb_demux_vc.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/demux_vc_pkg.sv
// Shared constants and helpers for the virtual-channel demultiplexer.
package demux_vc_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int VC_BIT_DEF = DATA_W_DEF - 1;
  localparam int VC0        = 0;
  localparam int VC1        = 1;
  localparam int NUM_VC     = 2;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_FULL = 2'd2;

  function automatic occ_t occ_after(input occ_t occ, input logic push, input logic pop);
    return occ + occ_t'(push) - occ_t'(pop);
  endfunction

endpackage

// File: rtl/demux_vc_if.sv
// Merged-stream input and per-VC output handshake bundle for demux_vc.
interface demux_vc_if #(
  parameter int DATA_W = demux_vc_pkg::DATA_W_DEF
);

  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic              ready_in;
  logic              pause_VC0;
  logic              pause_VC1;
  logic              valid_out_VC0;
  logic              valid_out_VC1;
  logic [DATA_W-1:0] data_out_VC0;
  logic [DATA_W-1:0] data_out_VC1;

  modport master (
    output valid_in, data_in, pause_VC0, pause_VC1,
    input  ready_in, valid_out_VC0, valid_out_VC1, data_out_VC0, data_out_VC1
  );

  modport slave (
    input  valid_in, data_in, pause_VC0, pause_VC1,
    output ready_in, valid_out_VC0, valid_out_VC1, data_out_VC0, data_out_VC1
  );

endinterface

// File: rtl/demux_vc_skid_buffer.sv
// vc_skid_buffer: 2-entry FIFO holding one VC's words; head stays visible after it drains.
module vc_skid_buffer
  import demux_vc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output occ_t              occ
);

  logic [DATA_W-1:0] ent0;
  logic [DATA_W-1:0] ent1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent0 <= '0;
      ent1 <= '0;
      occ  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) ent0 <= din;
          else             ent1 <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          // a lone pop from one entry leaves ent0 as the last-seen head
          if (occ == 2'd2) ent0 <= ent1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            ent0 <= ent1;
            ent1 <= din;
          end else begin
            ent0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = ent0;
  assign valid = (occ != 2'd0);

endmodule

// File: rtl/demux_vc.sv
// Virtual-channel demux: routes the merged stream to two skid buffers by class bit.
// Optional pop counters per VC when DEMUX_VC_STATS_EN is defined.
module demux_vc
  import demux_vc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int VC_BIT = DATA_W - 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
`ifdef DEMUX_VC_STATS_EN
  output logic [CNT_W-1:0] cnt_VC0,
  output logic [CNT_W-1:0] cnt_VC1,
`endif
  demux_vc_if.slave        bus
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("demux_vc: CNT_W must be at least 1");
  end

  logic              ready_q;
  logic              accept;
  logic [NUM_VC-1:0] push;
  logic [NUM_VC-1:0] pop;
  logic [NUM_VC-1:0] valid;
  occ_t              occ [NUM_VC];
  logic [DATA_W-1:0] dout [NUM_VC];

  assign accept    = bus.valid_in && ready_q;
  assign push[VC0] = accept && !bus.data_in[VC_BIT];
  assign push[VC1] = accept &&  bus.data_in[VC_BIT];
  assign pop[VC0]  = valid[VC0] && !bus.pause_VC0;
  assign pop[VC1]  = valid[VC1] && !bus.pause_VC1;

  vc_skid_buffer #(.DATA_W(DATA_W)) u_vc0 (
    .clk   (clk),
    .reset (reset),
    .push  (push[VC0]),
    .pop   (pop[VC0]),
    .din   (bus.data_in),
    .dout  (dout[VC0]),
    .valid (valid[VC0]),
    .occ   (occ[VC0])
  );

  vc_skid_buffer #(.DATA_W(DATA_W)) u_vc1 (
    .clk   (clk),
    .reset (reset),
    .push  (push[VC1]),
    .pop   (pop[VC1]),
    .din   (bus.data_in),
    .dout  (dout[VC1]),
    .valid (valid[VC1]),
    .occ   (occ[VC1])
  );

  // ready looks at post-update occupancy so an accepted word always has a free slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= (occ_after(occ[VC0], push[VC0], pop[VC0]) < OCC_FULL) &&
                 (occ_after(occ[VC1], push[VC1], pop[VC1]) < OCC_FULL);
    end
  end

  assign bus.ready_in      = ready_q;
  assign bus.valid_out_VC0 = valid[VC0];
  assign bus.valid_out_VC1 = valid[VC1];
  assign bus.data_out_VC0  = dout[VC0];
  assign bus.data_out_VC1  = dout[VC1];

`ifdef DEMUX_VC_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_VC0 <= '0;
      cnt_VC1 <= '0;
    end else begin
      if (pop[VC0]) cnt_VC0 <= cnt_VC0 + CNT_W'(1);
      if (pop[VC1]) cnt_VC1 <= cnt_VC1 + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_demux_vc.sv
// Testbench for demux_vc: directed vector table, reset corners and random traffic vs a queue model.
module tb_demux_vc;
  import demux_vc_pkg::*;

  localparam int DW = 6;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  demux_vc_if #(.DATA_W(DW)) bus ();

`ifdef DEMUX_VC_STATS_EN
  logic [CW-1:0] cnt_VC0;
  logic [CW-1:0] cnt_VC1;
`endif

  demux_vc #(.DATA_W(DW), .VC_BIT(DW-1), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset   (reset),
`ifdef DEMUX_VC_STATS_EN
    .cnt_VC0 (cnt_VC0),
    .cnt_VC1 (cnt_VC1),
`endif
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model: one queue per VC, capacity 2
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] last0, last1;
  bit            rdy_m;
  int unsigned   pops0, pops1;

  task automatic model_reset();
    q0.delete();
    q1.delete();
    last0 = '0;
    last1 = '0;
    rdy_m = 1'b0;
    pops0 = 0;
    pops1 = 0;
  endtask

  task automatic model_edge(input bit v, input logic [DW-1:0] d, input bit p0, input bit p1);
    bit acc;
    acc = v && rdy_m;
    if (q0.size() > 0 && !p0) begin
      void'(q0.pop_front());
      pops0++;
    end
    if (q1.size() > 0 && !p1) begin
      void'(q1.pop_front());
      pops1++;
    end
    if (acc) begin
      if (d[DW-1]) q1.push_back(d);
      else         q0.push_back(d);
    end
    if (q0.size() > 0) last0 = q0[0];
    if (q1.size() > 0) last1 = q1[0];
    rdy_m = (q0.size() < 2) && (q1.size() < 2);
  endtask

  task automatic check_model(input string tag);
    bit ev0, ev1;
    ev0 = (q0.size() != 0);
    ev1 = (q1.size() != 0);
    checks++;
    if (bus.ready_in !== rdy_m || bus.valid_out_VC0 !== ev0 || bus.data_out_VC0 !== last0 ||
        bus.valid_out_VC1 !== ev1 || bus.data_out_VC1 !== last1) begin
      errors++;
      $display("FAIL %s: got rdy=%0b v0=%0b d0=%h v1=%0b d1=%h, want rdy=%0b v0=%0b d0=%h v1=%0b d1=%h",
               tag, bus.ready_in, bus.valid_out_VC0, bus.data_out_VC0, bus.valid_out_VC1,
               bus.data_out_VC1, rdy_m, ev0, last0, ev1, last1);
    end
`ifdef DEMUX_VC_STATS_EN
    checks++;
    if (cnt_VC0 !== CW'(pops0) || cnt_VC1 !== CW'(pops1)) begin
      errors++;
      $display("FAIL %s cnt: got %0d/%0d, want %0d/%0d", tag, cnt_VC0, cnt_VC1,
               CW'(pops0), CW'(pops1));
    end
`endif
  endtask

  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit p0, input bit p1,
                     input string tag);
    bus.valid_in  = v;
    bus.data_in   = d;
    bus.pause_VC0 = p0;
    bus.pause_VC1 = p1;
    @(posedge clk);
    model_edge(v, d, p0, p1);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    bit            v;
    logic [DW-1:0] d;
    bit            p0;
    bit            p1;
    bit            e_rdy;
    bit            e_v0;
    logic [DW-1:0] e_d0;
    bit            e_v1;
    logic [DW-1:0] e_d1;
  } vec_t;

  vec_t tbl [18];

  initial begin
    // alternating routing, VC1 backpressure, independence, push+pop on one entry
    tbl[0]  = '{1, 6'h05, 0, 0, 1, 1, 6'h05, 0, 6'h00};
    tbl[1]  = '{1, 6'h25, 0, 0, 1, 0, 6'h05, 1, 6'h25};
    tbl[2]  = '{1, 6'h0A, 0, 0, 1, 1, 6'h0A, 0, 6'h25};
    tbl[3]  = '{1, 6'h3F, 0, 0, 1, 0, 6'h0A, 1, 6'h3F};
    tbl[4]  = '{0, 6'h00, 0, 0, 1, 0, 6'h0A, 0, 6'h3F};
    tbl[5]  = '{1, 6'h21, 0, 1, 1, 0, 6'h0A, 1, 6'h21};
    tbl[6]  = '{1, 6'h22, 0, 1, 0, 0, 6'h0A, 1, 6'h21};
    tbl[7]  = '{1, 6'h23, 0, 1, 0, 0, 6'h0A, 1, 6'h21};
    tbl[8]  = '{1, 6'h23, 0, 0, 1, 0, 6'h0A, 1, 6'h22};
    tbl[9]  = '{1, 6'h23, 0, 0, 1, 0, 6'h0A, 1, 6'h23};
    tbl[10] = '{0, 6'h00, 0, 0, 1, 0, 6'h0A, 0, 6'h23};
    tbl[11] = '{1, 6'h01, 1, 0, 1, 1, 6'h01, 0, 6'h23};
    tbl[12] = '{1, 6'h31, 1, 0, 1, 1, 6'h01, 1, 6'h31};
    tbl[13] = '{0, 6'h00, 1, 0, 1, 1, 6'h01, 0, 6'h31};
    tbl[14] = '{0, 6'h00, 0, 0, 1, 0, 6'h01, 0, 6'h31};
    tbl[15] = '{1, 6'h02, 0, 0, 1, 1, 6'h02, 0, 6'h31};
    tbl[16] = '{1, 6'h03, 0, 0, 1, 1, 6'h03, 0, 6'h31};
    tbl[17] = '{0, 6'h00, 0, 0, 1, 0, 6'h03, 0, 6'h31};

    reset         = 1'b1;
    bus.valid_in  = 1'b0;
    bus.data_in   = '0;
    bus.pause_VC0 = 1'b0;
    bus.pause_VC1 = 1'b0;
    model_reset();
    #12;
    check_model("reset_state");
    reset = 1'b0;
    cyc(0, '0, 0, 0, "ready_after_reset");

    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].p0, tbl[i].p1, $sformatf("tbl%0d_model", i));
      checks++;
      if (bus.ready_in !== tbl[i].e_rdy || bus.valid_out_VC0 !== tbl[i].e_v0 ||
          bus.data_out_VC0 !== tbl[i].e_d0 || bus.valid_out_VC1 !== tbl[i].e_v1 ||
          bus.data_out_VC1 !== tbl[i].e_d1) begin
        errors++;
        $display("FAIL tbl%0d: got rdy=%0b v0=%0b d0=%h v1=%0b d1=%h, want rdy=%0b v0=%0b d0=%h v1=%0b d1=%h",
                 i, bus.ready_in, bus.valid_out_VC0, bus.data_out_VC0, bus.valid_out_VC1,
                 bus.data_out_VC1, tbl[i].e_rdy, tbl[i].e_v0, tbl[i].e_d0, tbl[i].e_v1, tbl[i].e_d1);
      end
    end

    // asynchronous reset with VC0 full
    cyc(1, 6'h04, 1, 0, "fill_vc0_a");
    cyc(1, 6'h08, 1, 0, "fill_vc0_b");
    checks++;
    if (bus.ready_in !== 1'b0) begin
      errors++;
      $display("FAIL vc0_full_ready: got %0b, want 0", bus.ready_in);
    end
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_model("reset_async");
    @(posedge clk);
    #1;
    check_model("reset_hold");
    reset = 1'b0;
    cyc(0, '0, 0, 0, "reset_release");
    checks++;
    if (bus.ready_in !== 1'b1 || bus.valid_out_VC0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_direct: got rdy=%0b v0=%0b, want rdy=1 v0=0",
               bus.ready_in, bus.valid_out_VC0);
    end

`ifdef DEMUX_VC_STATS_EN
    for (int i = 0; i < 257; i++)
      cyc(1, DW'($urandom_range(0, 31)), 0, 0, "stats_stream");
    cyc(0, '0, 0, 0, "stats_drain");
    checks++;
    if (cnt_VC0 !== 8'd1 || cnt_VC1 !== 8'd0) begin
      errors++;
      $display("FAIL stats_wrap: got cnt0=%0d cnt1=%0d, want cnt0=1 cnt1=0", cnt_VC0, cnt_VC1);
    end
`endif

    for (int i = 0; i < 3000; i++) begin
      bit v, p0, p1;
      int mode;
      mode = (i / 500) % 3;
      v  = ($urandom_range(0, 3) != 0);
      p0 = (mode == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      p1 = (mode == 2) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      cyc(v, DW'($urandom), p0, p1, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
